// File: rtl/combi_isa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// combi_pkg
//   Shared types and helpers for the ARM/RISC-V ISA-mode controller.
//   - isa_state_t   : controller states (run, drain older instructions, flip mode)
//   - drain_cnt_w() : width of the drain timer, $clog2(DRAIN_CYCLES), minimum 1
// -----------------------------------------------------------------------------
package combi_pkg;

  typedef enum logic [1:0] {
    ISA_RUN    = 2'd0,
    ISA_DRAIN  = 2'd1,
    ISA_SWITCH = 2'd2
  } isa_state_t;

  // The timer is loaded with DRAIN_CYCLES-1, so $clog2(DRAIN_CYCLES) bits are
  // enough; a single-cycle drain still needs one bit to hold the value zero.
  function automatic int drain_cnt_w(input int drain_cycles);
    int w;
    w = $clog2(drain_cycles);
    if (w < 32'sd1) begin
      return 32'sd1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/combi_isa_ctrl_if.sv
// -----------------------------------------------------------------------------
// combi_isa_ctrl_if
//   Bundle between the Decode stage / hazard unit (master) and the ISA-mode
//   controller (slave).
//   master -> slave : armD (decoder ISA decision), validD (real instruction),
//                     FlushD (hazard-unit flush of Decode)
//   slave -> master : armIn (current mode), wasNotFlushed (registered ~FlushD),
//                     IsaStallF / IsaStallD / IsaFlushE (ORed into the hazard
//                     unit), switchBusy (switch in progress), switchCount
//                     (saturating count of completed switches)
// -----------------------------------------------------------------------------
interface combi_isa_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             armD;
  logic             validD;
  logic             FlushD;
  logic             armIn;
  logic             wasNotFlushed;
  logic             IsaStallF;
  logic             IsaStallD;
  logic             IsaFlushE;
  logic             switchBusy;
  logic [CNT_W-1:0] switchCount;

  modport master (
    output armD,
    output validD,
    output FlushD,
    input  armIn,
    input  wasNotFlushed,
    input  IsaStallF,
    input  IsaStallD,
    input  IsaFlushE,
    input  switchBusy,
    input  switchCount
  );

  modport slave (
    input  armD,
    input  validD,
    input  FlushD,
    output armIn,
    output wasNotFlushed,
    output IsaStallF,
    output IsaStallD,
    output IsaFlushE,
    output switchBusy,
    output switchCount
  );

endinterface

// File: rtl/combi_isa_ctrl.sv
// -----------------------------------------------------------------------------
// combi_isa_ctrl
//   ISA-mode controller for the combined ARM/RISC-V pipeline. Holds the
//   architectural mode that drives the decoder. When the instruction in Decode
//   resolves to the other ISA it freezes Fetch/Decode, bubbles Execute while
//   older instructions drain, flips the mode and then releases the held
//   instruction, which is re-decoded in the new mode.
//
// Parameters
//   RESET_ARM    : mode after reset (1 = ARM, 0 = RISC-V)
//   DRAIN_CYCLES : bubbles inserted before the flip (E/M/W depth), >= 1
//   CNT_W        : width of the completed-switch counter
//
// Ports
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : combi_isa_ctrl_if.slave (decoder/hazard-unit handshake)
// -----------------------------------------------------------------------------
module combi_isa_ctrl
  import combi_pkg::*;
#(
  parameter bit RESET_ARM    = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             reset,
  combi_isa_ctrl_if.slave bus
);

  localparam int               DCW        = drain_cnt_w(DRAIN_CYCLES);
  localparam logic [DCW-1:0]   DRAIN_LOAD = DCW'(DRAIN_CYCLES - 32'sd1);
  localparam logic [DCW-1:0]   DCNT_ONE   = DCW'(32'd1);
  localparam logic [DCW-1:0]   DCNT_ZERO  = DCW'(32'd0);
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] COUNT_MAX  = {CNT_W{1'b1}};

  isa_state_t       state_r;
  isa_state_t       state_s;
  logic             arm_r;
  logic             arm_s;
  logic             pending_r;
  logic             pending_s;
  logic [DCW-1:0]   dcnt_r;
  logic [DCW-1:0]   dcnt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             wnf_r;
  logic             busy_r;
  logic             stall_s;
  logic             mismatch_s;

  // An instruction only triggers a switch if it is real, was not flushed on
  // its way into Decode, is not being flushed now, and targets the other ISA.
  assign mismatch_s = bus.validD & wnf_r & ~bus.FlushD & (bus.armD != arm_r);

  // Next-state, timer, mode and counter logic plus the Mealy stall term.
  always_comb begin
    state_s   = state_r;
    arm_s     = arm_r;
    pending_s = pending_r;
    dcnt_s    = dcnt_r;
    count_s   = count_r;
    stall_s   = 1'b0;

    case (state_r)
      ISA_RUN: begin
        if (mismatch_s) begin
          // Stall in the detection cycle itself so the mismatching
          // instruction never reaches Execute.
          stall_s   = 1'b1;
          state_s   = ISA_DRAIN;
          pending_s = bus.armD;
          dcnt_s    = DRAIN_LOAD;
        end else begin
          state_s = ISA_RUN;
        end
      end

      ISA_DRAIN: begin
        stall_s = 1'b1;
        if (bus.FlushD) begin
          // Held instruction was on a wrong path: abandon without committing.
          state_s = ISA_RUN;
        end else if (dcnt_r == DCNT_ZERO) begin
          state_s = ISA_SWITCH;
          arm_s   = pending_r;
        end else begin
          dcnt_s = dcnt_r - DCNT_ONE;
        end
      end

      ISA_SWITCH: begin
        // Older instructions have all retired, so FlushD cannot abort here.
        stall_s = 1'b1;
        state_s = ISA_RUN;
        if (count_r != COUNT_MAX) begin
          count_s = count_r + COUNT_ONE;
        end else begin
          count_s = count_r;
        end
      end

      default: begin
        state_s = ISA_RUN;
      end
    endcase
  end

  // Controller registers; reset aborts any partial switch immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ISA_RUN;
      arm_r     <= RESET_ARM;
      pending_r <= RESET_ARM;
      dcnt_r    <= DCNT_ZERO;
      count_r   <= {CNT_W{1'b0}};
      wnf_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      arm_r     <= arm_s;
      pending_r <= pending_s;
      dcnt_r    <= dcnt_s;
      count_r   <= count_s;
      // Not gated by the stall: a held instruction stays marked unflushed.
      wnf_r     <= ~bus.FlushD;
      // Registered copy of (next state != RUN) is exactly the Moore busy flag.
      busy_r    <= (state_s != ISA_RUN);
    end
  end

  assign bus.armIn         = arm_r;
  assign bus.wasNotFlushed = wnf_r;
  assign bus.IsaStallF     = stall_s;
  assign bus.IsaStallD     = stall_s;
  assign bus.IsaFlushE     = stall_s;
  assign bus.switchBusy    = busy_r;
  assign bus.switchCount   = count_r;

endmodule

// File: tb/tb_combi_isa_ctrl.sv
// -----------------------------------------------------------------------------
// tb_combi_isa_ctrl
//   Directed bench for combi_isa_ctrl. Three instances:
//     dut0 : defaults (RESET_ARM=0, DRAIN_CYCLES=3, CNT_W=16)
//     dut1 : RESET_ARM=1
//     dut2 : CNT_W=4, DRAIN_CYCLES=1 (saturation / back-to-back switches)
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Flag vectors are {StallF, StallD, FlushE, Busy, armIn, wnf}.
// -----------------------------------------------------------------------------
module tb_combi_isa_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  combi_isa_ctrl_if #(.CNT_W(16)) if0 ();
  combi_isa_ctrl_if #(.CNT_W(16)) if1 ();
  combi_isa_ctrl_if #(.CNT_W(4))  if2 ();

  combi_isa_ctrl #(.RESET_ARM(1'b0), .DRAIN_CYCLES(3), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  combi_isa_ctrl #(.RESET_ARM(1'b1), .DRAIN_CYCLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );
  combi_isa_ctrl #(.RESET_ARM(1'b0), .DRAIN_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.validD = 1'b0; if0.armD = 1'b0; if0.FlushD = 1'b0;
    if1.validD = 1'b0; if1.armD = 1'b0; if1.FlushD = 1'b0;
    if2.validD = 1'b0; if2.armD = 1'b0; if2.FlushD = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    idle_inputs();
    #1;
    reset = 1'b1;
    #1;
    obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++; $display("FAIL reset_flags_arm0: got %b expected %b", obs, 6'b000000);
    end
    n_checks++;
    if (if0.switchCount !== 16'd0) begin
      n_fail++; $display("FAIL reset_count_arm0: got %0d expected 0", if0.switchCount);
    end
    obs = {if1.IsaStallF, if1.IsaStallD, if1.IsaFlushE, if1.switchBusy, if1.armIn, if1.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000010) begin
      n_fail++; $display("FAIL reset_flags_arm1: got %b expected %b", obs, 6'b000010);
    end
    n_checks++;
    if (if1.switchCount !== 16'd0) begin
      n_fail++; $display("FAIL reset_count_arm1: got %0d expected 0", if1.switchCount);
    end
    obs = {if2.IsaStallF, if2.IsaStallD, if2.IsaFlushE, if2.switchBusy, if2.armIn, if2.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000000 || if2.switchCount !== 4'd0) begin
      n_fail++; $display("FAIL reset_dut2: got %b/%0d expected 000000/0", obs, if2.switchCount);
    end
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    // After release and a clean cycle, dut1 still holds ARM and wnf is set.
    @(negedge clk);
    obs = {if1.IsaStallF, if1.IsaStallD, if1.IsaFlushE, if1.switchBusy, if1.armIn, if1.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000011) begin
      n_fail++; $display("FAIL post_reset_arm1: got %b expected %b", obs, 6'b000011);
    end
  endtask

  task automatic test_switch();
    logic [5:0]  obs;
    logic [5:0]  exp_v;
    logic [15:0] exp_c;
    do_reset();
    if0.validD = 1'b1; if0.armD = 1'b1; if0.FlushD = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      exp_v = {(k <= 4), (k <= 4), (k <= 4), (k >= 1 && k <= 4), (k >= 4), 1'b1};
      exp_c = (k >= 5) ? 16'd1 : 16'd0;
      obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL switch_flags k=%0d: got %b expected %b", k, obs, exp_v);
      end
      n_checks++;
      if (if0.switchCount !== exp_c) begin
        n_fail++; $display("FAIL switch_count k=%0d: got %0d expected %0d", k, if0.switchCount, exp_c);
      end
      cyc();
    end
    if0.validD = 1'b0;
  endtask

  task automatic test_abort();
    logic [5:0] obs;
    logic [5:0] exp_tab [5];
    exp_tab = '{6'b111001, 6'b111101, 6'b111101, 6'b000000, 6'b000001};
    do_reset();
    if0.armD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if0.validD = (k < 3);
      if0.FlushD = (k == 2);
      @(negedge clk);
      obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
      n_checks++;
      if (obs !== exp_tab[k]) begin
        n_fail++; $display("FAIL abort_flags k=%0d: got %b expected %b", k, obs, exp_tab[k]);
      end
      n_checks++;
      if (if0.switchCount !== 16'd0) begin
        n_fail++; $display("FAIL abort_count k=%0d: got %0d expected 0", k, if0.switchCount);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_flush_mismatch();
    logic [5:0] obs;
    logic [5:0] exp_tab [4];
    logic       val_tab [4];
    logic       fl_tab  [4];
    exp_tab = '{6'b000001, 6'b000000, 6'b000001, 6'b000001};
    val_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
    fl_tab  = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    if0.armD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if0.validD = val_tab[k];
      if0.FlushD = fl_tab[k];
      @(negedge clk);
      obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
      n_checks++;
      if (obs !== exp_tab[k]) begin
        n_fail++; $display("FAIL flush_mismatch k=%0d: got %b expected %b", k, obs, exp_tab[k]);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    do_reset();
    if0.validD = 1'b1; if0.armD = 1'b1; if0.FlushD = 1'b0;
    cyc();
    cyc();
    // Second DRAIN cycle.
    @(negedge clk);
    obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b111101) begin
      n_fail++; $display("FAIL midreset_before: got %b expected %b", obs, 6'b111101);
    end
    #1;
    reset = 1'b1;
    #1;
    obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000000 || if0.switchCount !== 16'd0) begin
      n_fail++; $display("FAIL midreset_async: got %b/%0d expected 000000/0", obs, if0.switchCount);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000000) begin
      n_fail++; $display("FAIL midreset_release: got %b expected %b", obs, 6'b000000);
    end
    cyc();
    @(negedge clk);
    obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b111001) begin
      n_fail++; $display("FAIL midreset_resume: got %b expected %b", obs, 6'b111001);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
    end
    @(negedge clk);
    obs = {if0.IsaStallF, if0.IsaStallD, if0.IsaFlushE, if0.switchBusy, if0.armIn, if0.wasNotFlushed};
    n_checks++;
    if (obs !== 6'b000011 || if0.switchCount !== 16'd1) begin
      n_fail++; $display("FAIL midreset_complete: got %b/%0d expected 000011/1", obs, if0.switchCount);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic       cur;
    logic [3:0] exp_c;
    do_reset();
    if2.FlushD = 1'b0;
    for (int s = 0; s < 20; s++) begin
      cur   = (s % 2) == 1;
      exp_c = (s > 15) ? 4'd15 : 4'(s);
      if2.validD = 1'b1;
      if2.armD   = ~cur;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        obs = {if2.IsaStallF, if2.IsaStallD, if2.IsaFlushE, if2.switchBusy, if2.armIn};
        if (k == 0) begin
          n_checks++;
          if (obs !== {4'b1110, cur}) begin
            n_fail++; $display("FAIL b2b_detect s=%0d: got %b expected %b", s, obs, {4'b1110, cur});
          end
          n_checks++;
          if (if2.switchCount !== exp_c) begin
            n_fail++; $display("FAIL b2b_count s=%0d: got %0d expected %0d", s, if2.switchCount, exp_c);
          end
        end else if (k == 1) begin
          n_checks++;
          if (obs !== {4'b1111, cur}) begin
            n_fail++; $display("FAIL b2b_drain s=%0d: got %b expected %b", s, obs, {4'b1111, cur});
          end
        end else begin
          n_checks++;
          if (obs !== {4'b1111, ~cur}) begin
            n_fail++; $display("FAIL b2b_switch s=%0d: got %b expected %b", s, obs, {4'b1111, ~cur});
          end
        end
        cyc();
      end
    end
    if2.validD = 1'b0;
    @(negedge clk);
    obs = {if2.IsaStallF, if2.IsaStallD, if2.IsaFlushE, if2.switchBusy, if2.armIn};
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++; $display("FAIL b2b_final_flags: got %b expected %b", obs, 5'b00000);
    end
    n_checks++;
    if (if2.switchCount !== 4'd15) begin
      n_fail++; $display("FAIL b2b_saturate: got %0d expected 15", if2.switchCount);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    test_reset();
    test_switch();
    test_abort();
    test_flush_mismatch();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
